reg_file: RTL and testbench

- 16-entry register file for the image-downsampling processor datapath, with 19-bit entries.
- Provides two combinational read ports (A, B) and one synchronous write port (C).
- Supports per-register synchronous clear through the reset select `RST_SEL`.
- Provides a memory-load path from data memory, and exports the address register and data register to the data-memory interface.

---
 rtl/reg_file.sv | 94 +++++++++
 tb/tb_reg_file.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   16-entry x 19-bit register file for the image-downsampling datapath.
//   Two combinational read ports (A, B), one synchronous write port (C),
//   per-register synchronous clear selected by RST_SEL, and a byte-wide
//   load path from data memory into DR. AR and the low byte of DR are
//   exported to the data-memory interface.
//
//   Register map: R0 = constant zero, R1 = AR, R2 = DR, R3..R15 = general.
//
// Ports
//   clk       in   1   clock; every state change happens on its rising edge
//   RST_SEL   in   4   nonzero: clear register[RST_SEL]; 0: no clear
//   C_SEL     in   4   write-port select; 0: no write
//   c_in      in   19  write-port data (stored verbatim)
//   A_SEL     in   4   read-port A select
//   B_SEL     in   4   read-port B select
//   MEM       in   2   00 idle, 01 load DR from mem_data, 10 store, 11 idle
//   mem_data  in   8   word read from data memory
//   a_out     out  19  register[A_SEL]
//   b_out     out  19  register[B_SEL]
//   dm_addr   out  19  AR (R1)
//   dm_data   out  8   DR[7:0] (R2 low byte)
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int DW   = 19,
    parameter int MW   = 8,
    parameter int NSEL = 4
) (
    input  logic            clk,
    input  logic [NSEL-1:0] RST_SEL,
    input  logic [NSEL-1:0] C_SEL,
    input  logic [DW-1:0]   c_in,
    input  logic [NSEL-1:0] A_SEL,
    input  logic [NSEL-1:0] B_SEL,
    input  logic [1:0]      MEM,
    input  logic [MW-1:0]   mem_data,
    output logic [DW-1:0]   a_out,
    output logic [DW-1:0]   b_out,
    output logic [DW-1:0]   dm_addr,
    output logic [MW-1:0]   dm_data
);

    localparam int              NREG     = 1 << NSEL;
    localparam logic [NSEL-1:0] AR_IDX   = NSEL'(1);
    localparam logic [NSEL-1:0] DR_IDX   = NSEL'(2);
    localparam logic [1:0]      MEM_LOAD = 2'b01;

    // Flat view of all registers; slot 0 is the hard-wired zero register so
    // the read muxes can index it directly without a special case.
    logic [NREG-1:0][DW-1:0] rf_view;
    logic                    mem_load;

    assign mem_load   = (MEM == MEM_LOAD);
    assign rf_view[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_reg
            localparam logic [NSEL-1:0] IDX = NSEL'(gi);

            // Power-up value is zero (FPGA register init); there is no
            // global reset, only the per-register clear via RST_SEL.
            logic [DW-1:0] reg_q = '0;
            logic [DW-1:0] reg_d;

            // Priority: clear, then memory load (DR only), then C write.
            always_comb begin
                reg_d = reg_q;
                if (RST_SEL == IDX) begin
                    reg_d = '0;
                end else if ((IDX == DR_IDX) && mem_load) begin
                    reg_d = {{(DW-MW){1'b0}}, mem_data};
                end else if (C_SEL == IDX) begin
                    reg_d = c_in;
                end
            end

            always_ff @(posedge clk) begin
                reg_q <= reg_d;
            end

            assign rf_view[gi] = reg_q;
        end
    endgenerate

    // Reads are purely combinational from stored state: no write-through.
    assign a_out   = rf_view[A_SEL];
    assign b_out   = rf_view[B_SEL];
    assign dm_addr = rf_view[AR_IDX];
    // Stores only carry the low byte of DR; upper DR bits are not exported.
    assign dm_data = rf_view[DR_IDX][MW-1:0];

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Directed test of reg_file. The stimulus process drives one transaction
//   per clock (inputs change on the falling edge) and queues hand-computed
//   expected outputs. A separate monitor pops the queue and compares: a
//   "pre" record is checked before the rising edge (old state visible), a
//   "post" record #1 after the rising edge (new state visible).
// ---------------------------------------------------------------------------
module tb_reg_file;

    logic        clk = 1'b0;
    logic [3:0]  RST_SEL = '0;
    logic [3:0]  C_SEL = '0;
    logic [18:0] c_in = '0;
    logic [3:0]  A_SEL = '0;
    logic [3:0]  B_SEL = '0;
    logic [1:0]  MEM = '0;
    logic [7:0]  mem_data = '0;
    logic [18:0] a_out;
    logic [18:0] b_out;
    logic [18:0] dm_addr;
    logic [7:0]  dm_data;

    reg_file dut (
        .clk      (clk),
        .RST_SEL  (RST_SEL),
        .C_SEL    (C_SEL),
        .c_in     (c_in),
        .A_SEL    (A_SEL),
        .B_SEL    (B_SEL),
        .MEM      (MEM),
        .mem_data (mem_data),
        .a_out    (a_out),
        .b_out    (b_out),
        .dm_addr  (dm_addr),
        .dm_data  (dm_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [18:0] a;
        logic [18:0] b;
        logic [18:0] addr;
        logic [7:0]  dm;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   pre_req  = 1'b0;
    bit   post_req = 1'b0;
    bit   stim_done = 1'b0;

    task automatic chk(input string name, input string field,
                       input logic [18:0] act, input logic [18:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", name, field, act, exp);
        end
    endtask

    task automatic check_rec(input string phase);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty got=0 want=1", phase);
        end else begin
            e = exp_q.pop_front();
            chk(e.name, "a_out", a_out, e.a);
            chk(e.name, "b_out", b_out, e.b);
            chk(e.name, "dm_addr", dm_addr, e.addr);
            chk(e.name, "dm_data", {11'b0, dm_data}, {11'b0, e.dm});
            $display("txn %-10s %s a=%h b=%h addr=%h dm=%h", e.name, phase,
                     a_out, b_out, dm_addr, dm_data);
        end
    endtask

    // Monitor: decoupled from stimulus, driven only by the request flags.
    initial begin
        bit post_now;
        forever begin
            @(negedge clk);
            #2;
            if (pre_req) check_rec("pre ");
            @(posedge clk);
            post_now = post_req;
            #1;
            if (post_now) check_rec("post");
        end
    end

    task automatic push(input string name, input logic [18:0] a,
                        input logic [18:0] b, input logic [18:0] addr,
                        input logic [7:0] dm);
        exp_t e;
        e.name = name; e.a = a; e.b = b; e.addr = addr; e.dm = dm;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of inputs at the falling edge.
    task automatic drive(input logic [3:0] rs, input logic [3:0] cs,
                         input logic [18:0] ci, input logic [3:0] as,
                         input logic [3:0] bs, input logic [1:0] mem,
                         input logic [7:0] md, input bit pre);
        @(negedge clk);
        RST_SEL = rs; C_SEL = cs; c_in = ci;
        A_SEL = as; B_SEL = bs; MEM = mem; mem_data = md;
        pre_req = pre;
        post_req = 1'b1;
    endtask

    initial begin
        //    rst   csel  c_in      asel  bsel  mem    md
        drive(4'd0, 4'd0, 19'h0,    4'd1, 4'd2, 2'b00, 8'h00, 1'b1);
        push("pwr", 19'h0, 19'h0, 19'h0, 8'h00);
        push("pwr", 19'h0, 19'h0, 19'h0, 8'h00);

        drive(4'd1, 4'd0, 19'h0,    4'd1, 4'd2, 2'b00, 8'h00, 1'b0);
        push("rst1", 19'h0, 19'h0, 19'h0, 8'h00);

        // a_out must stay 0 until the edge that takes c_in.
        drive(4'd0, 4'd1, 19'd10,   4'd1, 4'd2, 2'b00, 8'h00, 1'b1);
        push("wr1", 19'h0, 19'h0, 19'h0, 8'h00);
        push("wr1", 19'd10, 19'h0, 19'd10, 8'h00);

        drive(4'd0, 4'd0, 19'h0,    4'd2, 4'd1, 2'b01, 8'hA5, 1'b0);
        push("load", 19'h000A5, 19'd10, 19'd10, 8'hA5);

        drive(4'd0, 4'd2, 19'h7FFFF, 4'd2, 4'd1, 2'b01, 8'h3C, 1'b0);
        push("loadwin", 19'h0003C, 19'd10, 19'd10, 8'h3C);

        drive(4'd0, 4'd5, 19'd123,  4'd5, 4'd2, 2'b00, 8'h00, 1'b0);
        push("w5", 19'd123, 19'h0003C, 19'd10, 8'h3C);

        drive(4'd5, 4'd5, 19'd77,   4'd5, 4'd2, 2'b00, 8'h00, 1'b0);
        push("rstpri", 19'h0, 19'h0003C, 19'd10, 8'h3C);

        drive(4'd0, 4'd5, 19'd77,   4'd5, 4'd2, 2'b00, 8'h00, 1'b0);
        push("w5b", 19'd77, 19'h0003C, 19'd10, 8'h3C);

        drive(4'd0, 4'd0, 19'h12345, 4'd0, 4'd5, 2'b00, 8'h00, 1'b0);
        push("r0", 19'h0, 19'd77, 19'd10, 8'h3C);

        // Clear of R5 and write of R6 in the same edge both land.
        drive(4'd5, 4'd6, 19'h2AAAA, 4'd5, 4'd6, 2'b00, 8'h00, 1'b0);
        push("rst_wr", 19'h0, 19'h2AAAA, 19'd10, 8'h3C);

        // Load of DR and write of R7 in the same edge both land.
        drive(4'd0, 4'd7, 19'h00F0F, 4'd2, 4'd7, 2'b01, 8'h5A, 1'b0);
        push("ld_wr", 19'h0005A, 19'h00F0F, 19'd10, 8'h5A);

        // Clear of DR beats both the load and the C write.
        drive(4'd2, 4'd2, 19'h00001, 4'd2, 4'd1, 2'b01, 8'hFF, 1'b0);
        push("drrst", 19'h0, 19'd10, 19'd10, 8'h00);

        drive(4'd0, 4'd1, 19'h40000, 4'd1, 4'd2, 2'b00, 8'h00, 1'b0);
        push("set_ar", 19'h40000, 19'h0, 19'h40000, 8'h00);

        drive(4'd0, 4'd2, 19'h00155, 4'd1, 4'd2, 2'b00, 8'h00, 1'b0);
        push("set_dr", 19'h40000, 19'h00155, 19'h40000, 8'h55);

        drive(4'd0, 4'd0, 19'h0,    4'd1, 4'd2, 2'b10, 8'hEE, 1'b1);
        push("store", 19'h40000, 19'h00155, 19'h40000, 8'h55);
        push("store", 19'h40000, 19'h00155, 19'h40000, 8'h55);

        drive(4'd0, 4'd0, 19'h0,    4'd6, 4'd7, 2'b11, 8'h99, 1'b0);
        push("rdback", 19'h2AAAA, 19'h00F0F, 19'h40000, 8'h55);

        // Upper DR bits are dropped on the store byte.
        drive(4'd0, 4'd2, 19'h7FF80, 4'd2, 4'd1, 2'b00, 8'h00, 1'b0);
        push("trunc", 19'h7FF80, 19'h40000, 19'h40000, 8'h80);

        drive(4'd0, 4'd15, 19'h7FFFF, 4'd15, 4'd0, 2'b00, 8'h00, 1'b0);
        push("w15", 19'h7FFFF, 19'h0, 19'h40000, 8'h80);

        drive(4'd15, 4'd0, 19'h0,   4'd15, 4'd2, 2'b00, 8'h00, 1'b0);
        push("rst15", 19'h0, 19'h7FF80, 19'h40000, 8'h80);

        @(negedge clk);
        pre_req = 1'b0;
        post_req = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain leftover=%0d want=0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        if (!stim_done) begin
            $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
            $fatal(1, "timeout");
        end
    end

endmodule
